// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table harness stages.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK
  } state_e;

  // Widest table any harness stage builds (8-input gate).
  localparam int TT_W_MAX = 256;

  function automatic int tt_width(input int nInputs);
    return 1 << nInputs;
  endfunction

  function automatic int popcount(input logic [TT_W_MAX-1:0] x);
    int c;
    c = 0;
    for (int i = 0; i < TT_W_MAX; i++) begin
      c += int'(x[i]);
    end
    return c;
  endfunction

  // Index of the lowest set bit, or 0 when nothing is set.
  function automatic int lowest_set_index(input logic [TT_W_MAX-1:0] x);
    int idx;
    idx = 0;
    for (int i = TT_W_MAX - 1; i >= 0; i--) begin
      if (x[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tt_diff_reduce.sv
// Compares a captured truth table with the expected one and summarises the differences.
module tt_diff_reduce
  import tt_pkg::*;
#(
  parameter int N_INPUTS = 4
) (
  input  logic [2**N_INPUTS-1:0] captured_i,
  input  logic [2**N_INPUTS-1:0] expected_i,
  output logic                   match_o,
  output logic [N_INPUTS:0]      mismatch_count_o,
  output logic [N_INPUTS-1:0]    first_mismatch_idx_o
);

  localparam int TT_W  = tt_width(N_INPUTS);
  localparam int CNT_W = N_INPUTS + 1;
  localparam int IDX_W = N_INPUTS;

  logic [TT_W-1:0]     diff;
  logic [TT_W-1:0]     diffByVec;
  logic [TT_W_MAX-1:0] diffExt;

  // Tables are stored MSB-first, so flip into vector order before searching.
  always_comb begin
    diff      = captured_i ^ expected_i;
    diffByVec = '0;
    for (int v = 0; v < TT_W; v++) begin
      diffByVec[v] = diff[TT_W-1-v];
    end
    diffExt             = '0;
    diffExt[TT_W-1:0]   = diffByVec;
  end

  assign match_o              = (diff == '0);
  assign mismatch_count_o     = CNT_W'(popcount(diffExt));
  assign first_mismatch_idx_o = IDX_W'(lowest_set_index(diffExt));

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector through a combinational gate, captures its truth table
// and reports how it compares with the expected function.
module tt_sweep_checker
  import tt_pkg::*;
#(
  parameter int                    N_INPUTS      = 4,
  parameter logic [2**N_INPUTS-1:0] EXPECTED_TT  = 16'h429B,
  parameter int                    SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_INPUTS-1:0]    gate_in,
  input  logic                   gate_out,
  output logic                   busy,
  output logic                   done,
  output logic [2**N_INPUTS-1:0] captured_tt,
  output logic                   match,
  output logic [N_INPUTS:0]      mismatch_count,
  output logic [N_INPUTS-1:0]    first_mismatch_idx
);

  localparam int TT_W   = tt_width(N_INPUTS);
  localparam int WAIT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(SETTLE_CYCLES);
  localparam logic [N_INPUTS-1:0] IDX_LAST  = N_INPUTS'(TT_W - 1);

  state_e              state_q;
  logic [N_INPUTS-1:0] vecIdx_q;
  logic [N_INPUTS-1:0] gateIn_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [TT_W-1:0]     captured_q;
  logic [TT_W-1:0]     captured_d;
  logic                busy_q;
  logic                done_q;
  logic                match_q;
  logic [N_INPUTS:0]   mismatchCount_q;
  logic [N_INPUTS-1:0] firstMismatch_q;

  logic                reduceMatch;
  logic [N_INPUTS:0]   reduceCount;
  logic [N_INPUTS-1:0] reduceFirst;

  // Bit TT_W-1-v is simply the bitwise complement of v at N_INPUTS bits.
  always_comb begin
    captured_d            = captured_q;
    captured_d[~vecIdx_q] = gate_out;
  end

  tt_diff_reduce #(
    .N_INPUTS(N_INPUTS)
  ) u_reduce (
    .captured_i          (captured_q),
    .expected_i          (EXPECTED_TT),
    .match_o             (reduceMatch),
    .mismatch_count_o    (reduceCount),
    .first_mismatch_idx_o(reduceFirst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      vecIdx_q        <= '0;
      gateIn_q        <= '0;
      wait_q          <= '0;
      captured_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      match_q         <= 1'b0;
      mismatchCount_q <= '0;
      firstMismatch_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            vecIdx_q   <= '0;
            gateIn_q   <= '0;
            wait_q     <= '0;
            captured_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (wait_q != WAIT_LAST) begin
            wait_q <= wait_q + 1'b1;
          end else begin
            captured_q <= captured_d;
            wait_q     <= '0;
            if (vecIdx_q == IDX_LAST) begin
              state_q <= CHECK;
            end else begin
              vecIdx_q <= vecIdx_q + 1'b1;
              gateIn_q <= vecIdx_q + 1'b1;
            end
          end
        end
        CHECK: begin
          match_q         <= reduceMatch;
          mismatchCount_q <= reduceCount;
          firstMismatch_q <= reduceFirst;
          done_q          <= 1'b1;
          busy_q          <= 1'b0;
          gateIn_q        <= '0;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gate_in            = gateIn_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign captured_tt        = captured_q;
  assign match              = match_q;
  assign mismatch_count     = mismatchCount_q;
  assign first_mismatch_idx = firstMismatch_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Self-checking bench for tt_sweep_checker: table vectors, corner-case sequences and
// random gate functions checked against a truth-table reference model.
module tb_tt_sweep_checker;

  localparam logic [15:0] EXP = 16'h429B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  gateIn;
  logic        gateOut = 1'b0;
  logic        busy, done, match;
  logic [15:0] capturedTt;
  logic [4:0]  mismatchCount;
  logic [3:0]  firstIdx;

  logic        startZ = 1'b0;
  logic [3:0]  gateInZ;
  logic        gateOutZ;
  logic        busyZ, doneZ, matchZ;
  logic [15:0] capturedTtZ;
  logic [4:0]  mismatchCountZ;
  logic [3:0]  firstIdxZ;

  logic [15:0] gateTt  = EXP;
  logic [15:0] gateTtZ = EXP;
  logic [3:0]  prevIn  = 4'd0;
  int          age     = 0;

  int errorCount = 0;
  int checkCount = 0;

  tt_sweep_checker #(.N_INPUTS(4), .EXPECTED_TT(EXP), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .gate_in(gateIn), .gate_out(gateOut),
    .busy(busy), .done(done), .captured_tt(capturedTt), .match(match),
    .mismatch_count(mismatchCount), .first_mismatch_idx(firstIdx)
  );

  tt_sweep_checker #(.N_INPUTS(4), .EXPECTED_TT(EXP), .SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(startZ), .gate_in(gateInZ), .gate_out(gateOutZ),
    .busy(busyZ), .done(doneZ), .captured_tt(capturedTtZ), .match(matchZ),
    .mismatch_count(mismatchCountZ), .first_mismatch_idx(firstIdxZ)
  );

  // Slow gate: output is garbage until its input has been stable for two cycles.
  always @(posedge clk) begin
    #1;
    if (gateIn != prevIn) age = 0;
    else if (age < 1000) age++;
    prevIn  = gateIn;
    gateOut = (age >= 2) ? gateTt[4'(15 - int'(gateIn))] : 1'($urandom_range(0, 1));
  end

  assign gateOutZ = gateTtZ[4'(15 - int'(gateInZ))];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected results straight from the table definition, vector by vector.
  task automatic refModel(input logic [15:0] tt, output logic [15:0] cap, output logic m,
                          output int cnt, output int first);
    logic [15:0] e;
    bit found;
    e = EXP;
    cap = tt;
    m = (tt == e);
    cnt = 0;
    first = 0;
    found = 0;
    for (int v = 0; v < 16; v++) begin
      if (tt[15-v] != e[15-v]) begin
        cnt++;
        if (!found) first = v;
        found = 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] tt, output int latency);
    gateTt = tt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    checkOutput("busyAfterAccept", busy, 1);
    latency = 0;
    while (!done && latency < 200) begin
      tick();
      latency++;
    end
  endtask

  task automatic checkResults(input string tag, input logic [15:0] tt);
    logic [15:0] cap;
    logic m;
    int cnt, first;
    refModel(tt, cap, m, cnt, first);
    checkOutput({tag, ".captured"}, capturedTt, cap);
    checkOutput({tag, ".match"}, match, m);
    checkOutput({tag, ".count"}, mismatchCount, cnt);
    checkOutput({tag, ".first"}, firstIdx, first);
    checkOutput({tag, ".busyAtDone"}, busy, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".gateIn"}, gateIn, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".captured"}, capturedTt, 0);
    checkOutput({tag, ".match"}, match, 0);
    checkOutput({tag, ".count"}, mismatchCount, 0);
    checkOutput({tag, ".first"}, firstIdx, 0);
  endtask

  typedef struct {
    logic [15:0] tt;
    logic [15:0] cap;
    logic        m;
    int          cnt;
    int          first;
  } vec_t;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int lat, lat2, cyc, seqErr, busyErr, doneAt, guard;
    bit doneSeen;
    logic [15:0] firstCap, rtt;
    logic firstMatch;
    logic [4:0] firstCnt;
    logic [3:0] firstFirst;

    vecs[0] = '{16'h429B, 16'h429B, 1'b1, 0, 0};
    vecs[1] = '{16'h0000, 16'h0000, 1'b0, 7, 1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 9, 0};
    vecs[3] = '{16'h429A, 16'h429A, 1'b0, 1, 15};
    vecs[4] = '{16'hBD64, 16'hBD64, 1'b0, 16, 0};

    tick();
    checkResetValues("reset");
    tick();
    rst = 1'b0;
    tick();

    // Fixed table vectors with hand-derived expectations.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].tt, lat);
      checkOutput($sformatf("vec%0d.latency", i), lat, 49);
      checkOutput($sformatf("vec%0d.captured", i), capturedTt, vecs[i].cap);
      checkOutput($sformatf("vec%0d.match", i), match, vecs[i].m);
      checkOutput($sformatf("vec%0d.count", i), mismatchCount, vecs[i].cnt);
      checkOutput($sformatf("vec%0d.first", i), firstIdx, vecs[i].first);
      tick();
      checkOutput($sformatf("vec%0d.donePulse", i), done, 0);
      tick();
      checkOutput($sformatf("vec%0d.persist", i), mismatchCount, vecs[i].cnt);
    end

    // Reset in the middle of vector 7's settle window.
    gateTt = EXP;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (gateIn != 4'd7 && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("abort.reachedVec7", gateIn, 7);
    tick();
    rst = 1'b1;
    tick();
    checkResetValues("abort");
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) doneSeen = 1;
    end
    checkOutput("abort.noDone", doneSeen, 0);
    applyStimulus(EXP, lat);
    checkOutput("abort.rerunLatency", lat, 49);
    checkResults("abort.rerun", EXP);

    // Start held high across done: back-to-back sweeps.
    tick();
    gateTt = EXP;
    start = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    checkOutput("hold.latency1", lat, 49);
    checkOutput("hold.busyLowAtDone", busy, 0);
    firstCap = capturedTt;
    firstMatch = match;
    firstCnt = mismatchCount;
    firstFirst = firstIdx;
    tick();
    start = 1'b0;
    checkOutput("hold.busyAgain", busy, 1);
    checkOutput("hold.doneCleared", done, 0);
    lat2 = 0;
    while (!done && lat2 < 200) begin
      tick();
      lat2++;
    end
    checkOutput("hold.latency2", lat2, 49);
    checkOutput("hold.sameCaptured", capturedTt, firstCap);
    checkOutput("hold.sameMatch", match, firstMatch);
    checkOutput("hold.sameCount", mismatchCount, firstCnt);
    checkOutput("hold.sameFirst", firstIdx, firstFirst);
    checkResults("hold.run2", EXP);

    // Zero-settle sweep with stray start pulses while busy.
    tick();
    gateTtZ = EXP;
    startZ = 1'b1;
    tick();
    cyc = 0;
    seqErr = 0;
    busyErr = 0;
    doneAt = -1;
    while (cyc < 100) begin
      startZ = 1'b0;
      if (cyc <= 15 && gateInZ != 4'(cyc)) seqErr++;
      if (doneZ) begin
        doneAt = cyc;
        break;
      end
      if (!busyZ) busyErr++;
      if (cyc == 3 || cyc == 16) startZ = 1'b1;
      tick();
      cyc++;
    end
    checkOutput("zero.latency", doneAt, 17);
    checkOutput("zero.gateInSeq", seqErr, 0);
    checkOutput("zero.busyThroughout", busyErr, 0);
    checkOutput("zero.match", matchZ, 1);
    checkOutput("zero.captured", capturedTtZ, EXP);
    tick();
    checkOutput("zero.idleAfter", busyZ, 0);

    // Random gate functions against the reference model.
    for (int r = 0; r < 12; r++) begin
      rtt = 16'($urandom);
      tick();
      applyStimulus(rtt, lat);
      checkOutput($sformatf("rand%0d.latency", r), lat, 49);
      checkResults($sformatf("rand%0d", r), rtt);
    end
    for (int r = 0; r < 4; r++) begin
      logic [15:0] cap;
      logic m;
      int cnt, first;
      rtt = 16'($urandom);
      refModel(rtt, cap, m, cnt, first);
      gateTtZ = rtt;
      tick();
      startZ = 1'b1;
      tick();
      startZ = 1'b0;
      lat = 0;
      while (!doneZ && lat < 100) begin
        tick();
        lat++;
      end
      checkOutput($sformatf("randZ%0d.latency", r), lat, 17);
      checkOutput($sformatf("randZ%0d.captured", r), capturedTtZ, cap);
      checkOutput($sformatf("randZ%0d.match", r), matchZ, m);
      checkOutput($sformatf("randZ%0d.count", r), mismatchCountZ, cnt);
      checkOutput($sformatf("randZ%0d.first", r), firstIdxZ, first);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
